uart_tx_arbiter: RTL

//  Shares one uart_tx transmitter between NUM_REQ byte sources using round-robin arbitration.

---
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of signals between the byte sources, the arbiter and the uart_tx pins.
//   req/req_data/req_last : per-source request, byte and end-of-burst flag (packed)
//   req_ack               : per-source 1-cycle accept pulse
//   tx_start/tx_data      : start pulse and byte towards uart_tx
//   tx_busy               : busy flag from uart_tx
//   active_id/locked      : current or last grant, burst lock status
//   timeout_err           : tx_busy never rose after a start
// The slave modport is the arbiter's side; master is the client/uart side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [IDW-1:0]       active_id;
  logic                 locked;
  logic                 timeout_err;

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output req_ack, tx_start, tx_data, active_id, locked, timeout_err
  );

  modport master (
    output req, req_data, req_last, tx_busy,
    input  req_ack, tx_start, tx_data, active_id, locked, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources, with
// burst locking so a multi-byte packet from one source is never interleaved.
// Each byte is sequenced as: issue start, wait for busy to rise, wait for busy
// to fall. All outputs are registered.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : uart_tx_arbiter_if slave side (requests, acks, uart_tx pins, status)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrating; blocked while tx_busy is high (external user)
// ISSUE     | one cycle: tx_start and req_ack are being presented
// WAIT_BUSY | waiting for uart_tx to raise tx_busy, with timeout
// WAIT_DONE | byte in flight; waiting for tx_busy to drop
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [IDW-1:0]       active_id_q, active_id_d;
  logic                 locked_q, locked_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0]   owner_oh, win_oh, elig;
  logic [IDW:0]         cand_sum;
  logic [IDW-1:0]       win, nxt_ptr;
  logic                 found, grant, busy_to, byte_done;

  // Arbitration: scan from rr_ptr upward with wrap; a lock narrows the
  // candidate set to the owner, who must still be requesting.
  always_comb begin
    owner_oh              = '0;
    owner_oh[active_id_q] = 1'b1;
    elig     = locked_q ? (bus.req & owner_oh) : bus.req;
    found    = 1'b0;
    win      = '0;
    cand_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ)) cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      if (!found && elig[cand_sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand_sum[IDW-1:0];
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
    nxt_ptr   = (active_id_q == IDW'(NUM_REQ - 1)) ? '0 : active_id_q + 1'b1;
    grant     = (state_q == IDLE) && !bus.tx_busy && found;
    busy_to   = (state_q == WAIT_BUSY) && !bus.tx_busy && (cnt_q == '0);
    byte_done = (state_q == WAIT_DONE) && !bus.tx_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      req_ack_q     <= '0;
      tx_data_q     <= '0;
      active_id_q   <= '0;
      locked_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      req_ack_q     <= req_ack_d;
      tx_data_q     <= tx_data_d;
      active_id_q   <= active_id_d;
      locked_q      <= locked_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next state. The busy wait is a down-counter loaded in ISSUE so that
  // terminal count is reached after BUSY_TIMEOUT sampled cycles of WAIT_BUSY.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
          last_d  = bus.req_last[win];
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = CW'(BUSY_TIMEOUT - 1);
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (busy_to) begin
          state_d  = IDLE;
          rr_ptr_d = nxt_ptr;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (byte_done) begin
          state_d = IDLE;
          if (last_q) rr_ptr_d = nxt_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register inputs; tx_data and active_id hold until the next grant.
  always_comb begin
    tx_start_d    = grant;
    req_ack_d     = grant ? win_oh : '0;
    tx_data_d     = grant ? bus.req_data[{win, 3'b000} +: 8] : tx_data_q;
    active_id_d   = grant ? win : active_id_q;
    timeout_err_d = busy_to;
    locked_d      = locked_q;
    if (busy_to)   locked_d = 1'b0;
    if (byte_done) locked_d = !last_q;
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.active_id   = active_id_q;
  assign bus.locked      = locked_q;
  assign bus.timeout_err = timeout_err_q;
endmodule
